// File: rtl/bkm_step_stim_gen.sv
// Self-running stimulus source for the bkm_step bench: sweeps n, digit pairs and k with LFSR operands.
// Optional macro BKM_STIM_CORNER_EN replaces k=0/1 operands with max-positive/min-negative corners.
module bkm_step_stim_gen #(
  parameter int          WC     = 16,
  parameter int          WD     = 64,
  parameter int          LOG2N  = 6,
  parameter int          N_LAST = 15,
  parameter int          VECS   = 4,
  parameter logic [31:0] SEED   = 32'hACE1_2016
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic             cfg_mode,
  input  logic [1:0]       cfg_format,
  input  logic             stim_ready,
  output logic             stim_valid,
  output logic             tb_mode,
  output logic [1:0]       tb_format,
  output logic [LOG2N-1:0] tb_n,
  output logic [1:0]       tb_d_x_n,
  output logic [1:0]       tb_d_y_n,
  output logic [WD-1:0]    tb_X_n,
  output logic [WD-1:0]    tb_Y_n,
  output logic [WC-1:0]    tb_u_n,
  output logic [WC-1:0]    tb_v_n,
  output logic             busy,
  output logic             done,
  output logic [31:0]      vec_count
);
  localparam int KW = $clog2(VECS);
`ifdef BKM_STIM_CORNER_EN
  localparam bit CORNER_EN = 1'b1;
`else
  localparam bit CORNER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [LOG2N-1:0] n_q, n_nx;
  logic [1:0]       xi_q, xi_nx, yi_q, yi_nx;   // digit indices 0..2 (value = idx-1)
  logic [KW-1:0]    k_q, k_nx;
  logic [31:0]      lfsr_q, lfsr_nx;
  logic             load, accept, last;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [WD-1:0] rep32(input logic [31:0] s);
    logic [WD-1:0] r;
    for (int i = 0; i < WD; i++) r[i] = s[i % 32];
    return r;
  endfunction

  function automatic logic [1:0] enc(input logic [1:0] i);
    return {i == 2'd0, i != 2'd1};
  endfunction

  function automatic logic is_corner(input logic [KW-1:0] k);
    return CORNER_EN && (int'(k) < 2);
  endfunction

  assign accept     = (state == RUN) && stim_ready;
  assign last       = (n_q == LOG2N'(N_LAST)) && (xi_q == 2'd2) && (yi_q == 2'd2) &&
                      (k_q == KW'(VECS - 1));
  assign stim_valid = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    n_nx      = n_q;
    xi_nx     = xi_q;
    yi_nx     = yi_q;
    k_nx      = k_q;
    lfsr_nx   = lfsr_q;
    load      = 1'b0;
    case (state)
      RUN: begin
        if (stim_ready) begin
          if (!is_corner(k_q)) lfsr_nx = lfsr_step(lfsr_q);
          if (last) begin
            state_nxt = DONE;
          end else begin
            load = 1'b1;
            if (k_q != KW'(VECS - 1)) k_nx = k_q + 1'b1;
            else begin
              k_nx = '0;
              if (yi_q != 2'd2) yi_nx = yi_q + 2'd1;
              else begin
                yi_nx = 2'd0;
                if (xi_q != 2'd2) xi_nx = xi_q + 2'd1;
                else begin
                  xi_nx = 2'd0;
                  n_nx  = n_q + 1'b1;
                end
              end
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_nxt = RUN;
          n_nx      = '0;
          xi_nx     = 2'd0;
          yi_nx     = 2'd0;
          k_nx      = '0;
          lfsr_nx   = SEED;
          load      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      n_q       <= '0;
      xi_q      <= 2'd0;
      yi_q      <= 2'd0;
      k_q       <= '0;
      lfsr_q    <= SEED;
      vec_count <= '0;
      tb_mode   <= 1'b0;
      tb_format <= 2'd0;
      tb_n      <= '0;
      tb_d_x_n  <= 2'd0;
      tb_d_y_n  <= 2'd0;
      tb_X_n    <= '0;
      tb_Y_n    <= '0;
      tb_u_n    <= '0;
      tb_v_n    <= '0;
    end else if (enable) begin
      state  <= state_nxt;
      n_q    <= n_nx;
      xi_q   <= xi_nx;
      yi_q   <= yi_nx;
      k_q    <= k_nx;
      lfsr_q <= lfsr_nx;
      if (state != RUN && start) begin
        vec_count <= '0;
        tb_mode   <= cfg_mode;
        tb_format <= cfg_format;
      end else if (accept) begin
        vec_count <= vec_count + 32'd1;
      end
      // Operands always describe the vector at the next counter position.
      if (load) begin
        tb_n     <= n_nx;
        tb_d_x_n <= enc(xi_nx);
        tb_d_y_n <= enc(yi_nx);
        if (is_corner(k_nx) && k_nx == '0) begin
          tb_X_n <= {1'b0, {(WD-1){1'b1}}};
          tb_Y_n <= {1'b0, {(WD-1){1'b1}}};
          tb_u_n <= {1'b0, {(WC-1){1'b1}}};
          tb_v_n <= {1'b0, {(WC-1){1'b1}}};
        end else if (is_corner(k_nx)) begin
          tb_X_n <= {1'b1, {(WD-1){1'b0}}};
          tb_Y_n <= {1'b1, {(WD-1){1'b0}}};
          tb_u_n <= {1'b1, {(WC-1){1'b0}}};
          tb_v_n <= {1'b1, {(WC-1){1'b0}}};
        end else begin
          tb_X_n <= rep32(lfsr_nx);
          tb_Y_n <= rep32(~lfsr_nx);
          tb_u_n <= lfsr_nx[WC-1:0];
          tb_v_n <= lfsr_nx[31:32-WC];
        end
      end
    end
  end
endmodule

// File: tb/tb_bkm_step_stim_gen.sv
// Bench for bkm_step_stim_gen: scoreboard of the full expected sweep checked on every valid cycle.
module tb_bkm_step_stim_gen;
  localparam int          TOTAL = 576;
  localparam logic [31:0] SEED  = 32'hACE1_2016;

  logic        clk = 1'b0;
  logic        srst = 1'b1, enable = 1'b1, start = 1'b0, cfg_mode = 1'b0, stim_ready = 1'b0;
  logic [1:0]  cfg_format = 2'd0;
  logic        stim_valid, tb_mode, busy, done;
  logic [1:0]  tb_format, tb_d_x_n, tb_d_y_n;
  logic [5:0]  tb_n;
  logic [63:0] tb_X_n, tb_Y_n;
  logic [15:0] tb_u_n, tb_v_n;
  logic [31:0] vec_count;

  bkm_step_stim_gen dut (
    .clk(clk), .srst(srst), .enable(enable), .start(start), .cfg_mode(cfg_mode),
    .cfg_format(cfg_format), .stim_ready(stim_ready), .stim_valid(stim_valid),
    .tb_mode(tb_mode), .tb_format(tb_format), .tb_n(tb_n), .tb_d_x_n(tb_d_x_n),
    .tb_d_y_n(tb_d_y_n), .tb_X_n(tb_X_n), .tb_Y_n(tb_Y_n), .tb_u_n(tb_u_n),
    .tb_v_n(tb_v_n), .busy(busy), .done(done), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  n;
    logic [1:0]  dx, dy;
    logic [63:0] x, y;
    logic [15:0] u, v;
  } vec_t;

  vec_t       q[$];
  logic       exp_mode;
  logic [1:0] exp_fmt;
  int         n_vec = 0, n_err = 0;

  // Every valid cycle must show the head of the expected queue; pop on a real accept.
  always @(negedge clk) begin
    if (!srst && stim_valid) begin
      vec_t e;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty: valid with no expected vector, got n=%0d", tb_n);
      end else begin
        e = q[0];
        if ({tb_n, tb_d_x_n, tb_d_y_n, tb_X_n, tb_Y_n, tb_u_n, tb_v_n, tb_mode, tb_format} !==
            {e.n, e.dx, e.dy, e.x, e.y, e.u, e.v, exp_mode, exp_fmt}) begin
          n_err++;
          $display("FAIL sb_vec: got n=%0d d=%b/%b X=%h Y=%h u=%h v=%h m=%b f=%b want n=%0d d=%b/%b X=%h Y=%h u=%h v=%h m=%b f=%b",
                   tb_n, tb_d_x_n, tb_d_y_n, tb_X_n, tb_Y_n, tb_u_n, tb_v_n, tb_mode, tb_format,
                   e.n, e.dx, e.dy, e.x, e.y, e.u, e.v, exp_mode, exp_fmt);
        end
        if (enable && stim_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  task automatic build_exp();
    logic [31:0] s;
    vec_t e;
    int   dxi, dyi;
    q.delete();
    s = SEED;
    for (int n = 0; n < 16; n++)
      for (int p = 0; p < 9; p++)
        for (int k = 0; k < 4; k++) begin
          dxi  = p / 3 - 1;
          dyi  = p % 3 - 1;
          e.n  = 6'(n);
          e.dx = dxi[1:0];
          e.dy = dyi[1:0];
          e.x  = {s, s};
          e.y  = ~{s, s};
          e.u  = s[15:0];
          e.v  = s[31:16];
`ifdef BKM_STIM_CORNER_EN
          if (k == 0) begin
            e.x = 64'h7FFF_FFFF_FFFF_FFFF; e.y = e.x; e.u = 16'h7FFF; e.v = 16'h7FFF;
          end else if (k == 1) begin
            e.x = 64'h8000_0000_0000_0000; e.y = e.x; e.u = 16'h8000; e.v = 16'h8000;
          end else s = lfsr_next(s);
`else
          s = lfsr_next(s);
`endif
          q.push_back(e);
        end
  endtask

  task automatic do_start(input logic m, input logic [1:0] f);
    build_exp();
    exp_mode   = m;
    exp_fmt    = f;
    cfg_mode   = m;
    cfg_format = f;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic run_to_done(input bit toggle, output int vcyc);
    bit ph = 1'b0;
    int guard = 0;
    vcyc = 0;
    while (!done && guard < 3000) begin
      stim_ready = !toggle || !ph;
      if (stim_valid) begin
        vcyc++;
        ph = ~ph;
      end
      tick();
      guard++;
    end
    stim_ready = 1'b0;
    if (!done) begin
      n_err++;
      $display("FAIL sweep_timeout: done=%b after %0d cycles, want done=1", done, guard);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1; enable = 1'b1; start = 1'b0; stim_ready = 1'b0;
    tick(); tick();
    srst = 1'b0;
    n_vec++;
    if ({stim_valid, busy, done, tb_mode, tb_format, tb_n, tb_d_x_n, tb_d_y_n, tb_X_n, tb_Y_n, tb_u_n, tb_v_n} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b X=%h u=%h, want all 0", stim_valid, busy, done, tb_X_n, tb_u_n);
    end
    n_vec++;
    if (vec_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0", vec_count);
    end
  endtask

  task automatic test_full_ready();
    int v;
    do_start(1'b1, 2'b10);
    n_vec++;
`ifdef BKM_STIM_CORNER_EN
    if ({tb_n, tb_d_x_n, tb_d_y_n, tb_u_n, busy} !== {6'd0, 2'b11, 2'b11, 16'h7FFF, 1'b1}) begin
`else
    if ({tb_n, tb_d_x_n, tb_d_y_n, tb_X_n[31:0], busy} !== {6'd0, 2'b11, 2'b11, 32'hACE12016, 1'b1}) begin
`endif
      n_err++;
      $display("FAIL first_vec: got n=%0d d=%b/%b X=%h u=%h busy=%b", tb_n, tb_d_x_n, tb_d_y_n, tb_X_n, tb_u_n, busy);
    end
    run_to_done(1'b0, v);
    n_vec++;
    if (v !== TOTAL) begin n_err++; $display("FAIL full_valid_cycles: got %0d want %0d", v, TOTAL); end
    n_vec++;
    if ({done, busy, stim_valid, vec_count} !== {3'b100, 32'd576}) begin
      n_err++;
      $display("FAIL full_done: done=%b busy=%b valid=%b count=%0d want 1/0/0/576", done, busy, stim_valid, vec_count);
    end
    n_vec++;
    if ({tb_mode, tb_format, tb_n, q.size()} !== {1'b1, 2'b10, 6'd15, 32'd0}) begin
      n_err++;
      $display("FAIL full_hold: mode=%b fmt=%b n=%0d left=%0d want 1/10/15/0", tb_mode, tb_format, tb_n, q.size());
    end
  endtask

  task automatic test_toggle_ready();
    int v;
    do_start(1'b1, 2'b10);
    run_to_done(1'b1, v);
    n_vec++;
    if (v !== 1151) begin n_err++; $display("FAIL toggle_cycles: got %0d want 1151", v); end
    n_vec++;
    if (vec_count !== 32'd576 || q.size() != 0) begin
      n_err++;
      $display("FAIL toggle_count: got %0d left=%0d want 576/0", vec_count, q.size());
    end
  endtask

  task automatic test_digits();
    do_start(1'b0, 2'b01);
    stim_ready = 1'b1;
    for (int i = 0; i < TOTAL; i++) begin
      n_vec++;
      if (!stim_valid || tb_n !== 6'(i / 36) || tb_d_x_n === 2'b10 || tb_d_y_n === 2'b10) begin
        n_err++;
        $display("FAIL digit_seq: i=%0d valid=%b n=%0d d=%b/%b want n=%0d", i, stim_valid, tb_n, tb_d_x_n, tb_d_y_n, i / 36);
      end
`ifdef BKM_STIM_CORNER_EN
      n_vec++;
      if ((i % 4 == 0 && tb_u_n !== 16'h7FFF) || (i % 4 == 1 && tb_u_n !== 16'h8000)) begin
        n_err++;
        $display("FAIL corner_u: i=%0d got %h", i, tb_u_n);
      end
`endif
      tick();
    end
    stim_ready = 1'b0;
    n_vec++;
    if ({done, tb_n} !== {1'b1, 6'd15}) begin
      n_err++;
      $display("FAIL digit_end: done=%b n=%0d want 1/15", done, tb_n);
    end
  endtask

  task automatic test_abort();
    int v;
    do_start(1'b1, 2'b10);
    stim_ready = 1'b1;
    repeat (100) tick();
    stim_ready = 1'b0;
    n_vec++;
    if (vec_count !== 32'd100) begin n_err++; $display("FAIL abort_pre: got %0d want 100", vec_count); end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    n_vec++;
    if ({stim_valid, busy, done, vec_count, tb_n, tb_X_n, tb_u_n, tb_v_n, tb_mode} !== '0) begin
      n_err++;
      $display("FAIL abort_reset: valid=%b busy=%b done=%b count=%0d X=%h want all 0", stim_valid, busy, done, vec_count, tb_X_n);
    end
    do_start(1'b1, 2'b10);
    n_vec++;
    if (vec_count !== 32'd0 || tb_n !== 6'd0) begin
      n_err++;
      $display("FAIL abort_restart: count=%0d n=%0d want 0/0", vec_count, tb_n);
    end
    run_to_done(1'b0, v);
    n_vec++;
    if (vec_count !== 32'd576 || v !== TOTAL) begin
      n_err++;
      $display("FAIL abort_total: count=%0d cycles=%0d want 576/576", vec_count, v);
    end
  endtask

  task automatic test_enable_freeze();
    int v;
    do_start(1'b1, 2'b00);
    stim_ready = 1'b1;
    repeat (50) tick();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (vec_count !== 32'd50 || !stim_valid) begin
        n_err++;
        $display("FAIL enable_freeze: cyc=%0d count=%0d valid=%b want 50/1", i, vec_count, stim_valid);
      end
    end
    enable = 1'b1;
    run_to_done(1'b0, v);
    n_vec++;
    if (vec_count !== 32'd576 || v !== 526 || q.size() != 0) begin
      n_err++;
      $display("FAIL enable_total: count=%0d cycles=%0d left=%0d want 576/526/0", vec_count, v, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_ready();
    test_toggle_ready();
    test_digits();
    test_abort();
    test_enable_freeze();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bkm_step_stim_gen.md
Name: bkm_step_stim_gen

Overview:
Self-running stimulus generator for the bkm_step block bench. It produces the per-step inputs that the DUT and the step checker consume: mode, format, iteration index n, digit pair and X/Y/u/v operands. It sweeps every iteration index and every signed-digit pair deterministically, with pseudo-random operands, and delivers vectors over a valid/ready handshake. It sits upstream of the DUT and checker in the bkm_step testbench.

Parameters:
WC, 16, control-path (u/v) width; must be <= 32
WD, 64, data-path (X/Y) width; must be >= 32
LOG2N, 6, width of iteration index n
N_LAST, 15, last iteration index swept (n = 0..N_LAST); must be < 2**LOG2N
VECS, 4, vectors emitted per (n, digit pair); must be >= 2
SEED, 32'hACE1_2016, LFSR reset/start seed; must be non-zero

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
enable  in  1  clock enable; when low all state holds
start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE
cfg_mode  in  1  mode latched at start
cfg_format  in  2  format latched at start
stim_ready  in  1  consumer accepts the current vector
stim_valid  out  1  vector on the tb_* outputs is valid
tb_mode  out  1  latched mode
tb_format  out  2  latched format
tb_n  out  LOG2N  iteration index
tb_d_x_n  out  2  x digit
tb_d_y_n  out  2  y digit
tb_X_n  out  WD  X operand
tb_Y_n  out  WD  Y operand
tb_u_n  out  WC  u operand
tb_v_n  out  WC  v operand
busy  out  1  high in RUN
done  out  1  high in DONE
vec_count  out  32  number of accepted vectors in the current or last sweep

Behaviour:
- Clock and reset: one clock, clk. Reset is srst, synchronous and active-high. srst has priority over enable.
- Reset values: all outputs 0, FSM in IDLE, LFSR = SEED. srst during RUN aborts the sweep immediately; there is no partial done.
- enable=0 freezes the FSM, the counters, the LFSR and all outputs. An accept (stim_valid & stim_ready) in a cycle with enable=0 is ignored.
- Digit encoding: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1. Code 2'b10 is never generated.
- Digit pair index p = 0..8: d_x = enc(p/3 - 1), d_y = enc(p%3 - 1). So p=0 gives (11,11), p=4 gives (00,00), p=8 gives (01,01).
- Sweep order (nested, innermost first): vector k = 0..VECS-1, then p = 0..8, then n = 0..N_LAST. Total vectors per sweep = (N_LAST+1)*9*VECS = 576 with the defaults.
- LFSR: 32-bit Fibonacci, taps 32,22,2,1. It advances one step per accepted vector.
- Operand mapping from LFSR state s:
  - tb_X_n = s replicated from the LSB and truncated to WD.
  - tb_Y_n = ~s, mapped the same way.
  - tb_u_n = s[WC-1:0].
  - tb_v_n = s[31:32-WC].
- FSM states:
  - IDLE: stim_valid=0. start moves to RUN on the next cycle. On entry to RUN: cfg_mode/cfg_format latched, n=p=k=0, vec_count=0, LFSR reloaded with SEED.
  - RUN: stim_valid=1. The first vector is valid one cycle after start. On accept: vec_count+1, counters and LFSR advance, and the next vector appears the following cycle. Back-to-back accepts give one vector per cycle. While stim_valid & !stim_ready, every tb_* output holds stable. start is ignored in RUN.
  - The accept of the last vector (n=N_LAST, p=8, k=VECS-1) moves to DONE, and stim_valid drops in that same transition.
  - DONE: done=1, stim_valid=0, tb_* hold the last vector, vec_count holds the total. start restarts the sweep exactly as from IDLE.
- start and srst in the same cycle: srst wins.

Optional Feature:
Macro BKM_STIM_CORNER_EN.
- Defined: vectors k=0 and k=1 of every (n, p) use corner operands instead of LFSR values:
  - k=0: X = Y = {1'b0,{WD-1{1'b1}}}, u = v = {1'b0,{WC-1{1'b1}}}.
  - k=1: X = Y = {1'b1,{WD-1{1'b0}}}, u = v = {1'b1,{WC-1{1'b0}}}.
  - The LFSR does not advance on corner vectors.
- Undefined: all vectors come from the LFSR. Ordering, counts and handshake are identical in both builds.

Test Plan:
1. Reset, then start with cfg_mode=1, cfg_format=2'b10 and stim_ready held 1 -> exactly 576 consecutive stim_valid cycles; first vector n=0, d=(11,11), X_n[31:0]=32'hACE12016; done=1 with vec_count=576; tb_mode=1 and tb_format=10 throughout.
2. stim_ready toggled 1/0 every cycle -> sweep takes 1151 cycles; tb_* stable in every stalled cycle; vector sequence identical to scenario 1.
3. Check digit sequence -> tb_d_x_n/tb_d_y_n step through the 9 pairs, each held for 4 vectors; 2'b10 never appears; tb_n increments every 36 accepts and ends at 15.
4. srst asserted after 100 accepts, then start -> outputs zero with busy=0 the cycle after srst; the new sweep repeats scenario 1 from vector 0 with vec_count restarting at 0.
5. enable=0 for 10 cycles mid-run with stim_ready=1 -> no accepts counted; outputs and vec_count frozen; sweep still totals 576.
6. Build with BKM_STIM_CORNER_EN -> for every (n, p), k=0 gives tb_u_n=16'h7FFF and k=1 gives tb_u_n=16'h8000; k=2 of the first pair gives X_n[31:0]=32'hACE12016.
